// File: rtl/oam_dma_if.sv
// oam_dma_if: system-bus snoop, arbiter handshake and status signals of the sprite DMA
interface oam_dma_if;
    logic [15:0] snoop_addr;
    logic        snoop_we;
    logic [7:0]  bus_data_in;
    logic        bus_req;
    logic        bus_rdy;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data_out;
    logic        bus_data_oe;
    logic        busy;
    logic        done;
    modport master (
        input  snoop_addr, snoop_we, bus_data_in, bus_rdy,
        output bus_req, bus_we, bus_addr, bus_data_out, bus_data_oe, busy, done
    );
    modport slave (
        output snoop_addr, snoop_we, bus_data_in, bus_rdy,
        input  bus_req, bus_we, bus_addr, bus_data_out, bus_data_oe, busy, done
    );
endinterface

// File: rtl/oam_dma.sv
// oam_dma: sprite DMA master copying one 256-byte page into the PPU OAM data port
module oam_dma #(
    parameter logic [15:0] TRIG_ADDR = 16'h4014,
    parameter logic [15:0] OAM_PORT  = 16'h2004
) (
    input logic       clk,
    input logic       n_reset,
    oam_dma_if.master bus
);
    typedef enum logic [1:0] {IDLE, ALIGN, READ, WRITE} state_t;
    state_t     state_q, state_d;
    logic [7:0] page_q, page_d, idx_q, idx_d, dbuf_q, dbuf_d;
    logic       cyc_odd_q, cyc_odd_d, done_q, done_d;
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q   <= IDLE;
            page_q    <= 8'h00;
            idx_q     <= 8'h00;
            dbuf_q    <= 8'h00;
            cyc_odd_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            page_q    <= page_d;
            idx_q     <= idx_d;
            dbuf_q    <= dbuf_d;
            cyc_odd_q <= cyc_odd_d;
            done_q    <= done_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        page_d    = page_q;
        idx_d     = idx_q;
        dbuf_d    = dbuf_q;
        done_d    = 1'b0;
        cyc_odd_d = ~cyc_odd_q;
        case (state_q)
            IDLE: if (bus.snoop_we && bus.snoop_addr == TRIG_ADDR) begin
                page_d  = bus.bus_data_in;
                idx_d   = 8'h00;
                state_d = ALIGN;
            end
            ALIGN: if (bus.bus_rdy) state_d = READ;
            // a read only lands on an edge that starts an even cycle
            READ: if (bus.bus_rdy && !cyc_odd_d) begin
                dbuf_d  = bus.bus_data_in;
                state_d = WRITE;
            end
            WRITE: if (bus.bus_rdy) begin
                idx_d   = idx_q + 8'd1;
                state_d = (idx_q == 8'hFF) ? IDLE : READ;
                done_d  = (idx_q == 8'hFF);
            end
            default: state_d = IDLE;
        endcase
    end
    assign bus.bus_req      = (state_q != IDLE);
    assign bus.busy         = (state_q != IDLE);
    assign bus.bus_we       = (state_q == WRITE);
    assign bus.bus_addr     = (state_q == WRITE) ? OAM_PORT : (state_q == IDLE) ? 16'h0000 : {page_q, idx_q};
    assign bus.bus_data_out = (state_q == WRITE) ? dbuf_q : 8'h00;
    assign bus.bus_data_oe  = bus.bus_rdy & (state_q == WRITE);
    assign bus.done         = done_q;
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: table-driven transfers plus hand-written retrigger, reset and page-wrap sequences
module tb_oam_dma;
    typedef struct {
        logic [7:0] page;
        logic       phase;
        logic       rnd;
        int         grants;
    } vec_t;
    logic        clk = 1'b0, n_reset = 1'b0;
    logic        par = 1'b0, rdy_rand = 1'b0, cpu_drv = 1'b0;
    logic [7:0]  cpu_data = 8'h00, exp_page = 8'h00;
    logic [7:0]  mem [0:65535];
    int          checks = 0, errors = 0;
    int          grants = 0, writes = 0, rd_err = 0, wr_err = 0, stab_err = 0, lat_err = 0, dones = 0;
    logic        p_hold = 1'b0, p_we = 1'b0;
    logic [15:0] p_addr = 16'h0000;
    logic [7:0]  p_dout = 8'h00;
    vec_t        vecs [5];
    oam_dma_if bus();
    oam_dma dut (.clk(clk), .n_reset(n_reset), .bus(bus));
    always #5 clk = ~clk;
    assign bus.bus_data_in = cpu_drv ? cpu_data : mem[bus.bus_addr];
    always @(posedge clk) par <= n_reset ? ~par : 1'b0;
    always @(posedge clk) begin
        #1;
        bus.bus_rdy = rdy_rand ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end
    always @(negedge clk) begin
        if (n_reset && bus.bus_req) begin
            if (p_hold && (bus.bus_addr !== p_addr || bus.bus_we !== p_we || bus.bus_data_out !== p_dout)) stab_err++;
            if (bus.bus_data_oe !== (bus.bus_rdy & bus.bus_we)) stab_err++;
            if (bus.bus_we && !p_we && par) lat_err++;
            if (bus.bus_rdy) begin
                grants++;
                if (bus.bus_we) begin
                    if (bus.bus_addr !== 16'h2004 || bus.bus_data_out !== mem[{exp_page, writes[7:0]}]) wr_err++;
                    writes++;
                end else if (bus.bus_addr !== {exp_page, writes[7:0]}) rd_err++;
            end
            p_hold = !bus.bus_rdy;
            p_we   = bus.bus_we;
            p_addr = bus.bus_addr;
            p_dout = bus.bus_data_out;
        end else begin
            if (bus.bus_data_oe) stab_err++;
            p_hold = 1'b0;
            p_we   = 1'b0;
        end
        if (bus.done) dones++;
    end
    task automatic step();
        @(posedge clk);
        #2;
    endtask
    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic clr();
        grants = 0; writes = 0; rd_err = 0; wr_err = 0; stab_err = 0; lat_err = 0; dones = 0;
    endtask
    task automatic trigger(logic [7:0] page, logic phase);
        int n = 0;
        while (par !== phase && n < 4) begin
            step();
            n++;
        end
        bus.snoop_addr = 16'h4014;
        bus.snoop_we   = 1'b1;
        cpu_data       = page;
        cpu_drv        = 1'b1;
        step();
        bus.snoop_we   = 1'b0;
        bus.snoop_addr = 16'h0000;
        cpu_drv        = 1'b0;
    endtask
    task automatic wait_done();
        int n = 0;
        while (dones == 0 && n < 5000) begin
            step();
            n++;
        end
    endtask
    task automatic post(string name);
        chk({name, " req_after"}, int'(bus.bus_req), 0);
        chk({name, " busy_after"}, int'(bus.busy), 0);
        chk({name, " writes"}, writes, 256);
        chk({name, " rd_addr_err"}, rd_err, 0);
        chk({name, " wr_data_err"}, wr_err, 0);
        chk({name, " stable_err"}, stab_err, 0);
        chk({name, " odd_latch_err"}, lat_err, 0);
        step();
        step();
        chk({name, " done_pulses"}, dones, 1);
    endtask
    task automatic run(string name, logic [7:0] page, logic phase, logic rnd, int exp_grants);
        exp_page = page;
        rdy_rand = rnd;
        clr();
        trigger(page, phase);
        chk({name, " busy_start"}, int'(bus.busy), 1);
        chk({name, " req_start"}, int'(bus.bus_req), 1);
        wait_done();
        if (exp_grants > 0) chk({name, " grants"}, grants, exp_grants);
        post(name);
    endtask
    initial begin
        int n;
        for (int a = 0; a < 65536; a++)
            mem[a] = (a[15:8] == 8'h02) ? (a[7:0] ^ 8'h5A) : (a[7:0] ^ a[15:8] ^ 8'hC3);
        bus.snoop_addr = 16'h0000;
        bus.snoop_we   = 1'b0;
        vecs[0] = '{8'h02, 1'b1, 1'b0, 513};
        vecs[1] = '{8'h02, 1'b0, 1'b0, 514};
        vecs[2] = '{8'h02, 1'b1, 1'b1, 0};
        vecs[3] = '{8'hFF, 1'b0, 1'b0, 514};
        vecs[4] = '{8'hA5, 1'b1, 1'b1, 0};
        repeat (3) step();
        chk("rst bus_req", int'(bus.bus_req), 0);
        chk("rst busy", int'(bus.busy), 0);
        chk("rst done", int'(bus.done), 0);
        chk("rst oe", int'(bus.bus_data_oe), 0);
        chk("rst we", int'(bus.bus_we), 0);
        chk("rst addr", int'(bus.bus_addr), 0);
        chk("rst dout", int'(bus.bus_data_out), 0);
        n_reset = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            run($sformatf("vec%0d", i), vecs[i].page, vecs[i].phase, vecs[i].rnd, vecs[i].grants);
            repeat (3) step();
        end
        exp_page = 8'h02;
        rdy_rand = 1'b0;
        clr();
        trigger(8'h02, 1'b1);
        n = 0;
        while ((writes < 10 || !bus.bus_we) && n < 100) begin
            step();
            n++;
        end
        bus.snoop_addr = 16'h4014;
        bus.snoop_we   = 1'b1;
        cpu_data       = 8'h07;
        cpu_drv        = 1'b1;
        step();
        bus.snoop_we   = 1'b0;
        bus.snoop_addr = 16'h0000;
        cpu_drv        = 1'b0;
        wait_done();
        chk("retrig grants", grants, 513);
        post("retrig");
        clr();
        trigger(8'h02, 1'b0);
        n = 0;
        while (writes < 100 && n < 1000) begin
            step();
            n++;
        end
        n_reset = 1'b0;
        step();
        chk("midrst req", int'(bus.bus_req), 0);
        chk("midrst oe", int'(bus.bus_data_oe), 0);
        chk("midrst busy", int'(bus.busy), 0);
        chk("midrst done", int'(bus.done), 0);
        n_reset = 1'b1;
        repeat (3) step();
        chk("midrst no_done", dones, 0);
        chk("midrst idle", int'(bus.bus_req), 0);
        run("page03", 8'h03, 1'b1, 1'b0, 513);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
